uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Byte FIFO with launch FSM, directly upstream of the Uart8 transmitter.
//  Accepts bytes from a producer over valid/ready and buffers them.
//  Sequences txStart/in into Uart8 one frame at a time, paced by Uart8's txBusy.
//  The producer never has to watch baud timing.
// PARAMETERS
//  DEPTH    16  FIFO entries; must be a power of two, minimum 2
//  ADDR_W   $clog2(DEPTH)  localparam, derived; do not override
// PORTS
//  clk      in   1        system clock, the same clock as Uart8
//  reset    in   1        asynchronous, active-high; clears FIFO and FSM
//  wrData   in   8        byte to enqueue
//  wrValid  in   1        producer offers wrData this cycle
//  wrReady  out  1        FIFO can accept; a push occurs when wrValid&&wrReady
//  txEn     in   1        mirrors Uart8 txEn; launches permitted only when high
//  txBusy   in   1        from Uart8 txBusy
//  txStart  out  1        to Uart8 txStart
//  txByte   out  8        to Uart8 in; equals FIFO head while txStart high
//  empty    out  1        FIFO holds 0 entries
//  full     out  1        FIFO holds DEPTH entries
// BEHAVIOUR
//  Reset values: wrReady=1, txStart=0, txByte=8'h00, empty=1, full=0.
//   Pointers and count are 0; FSM is in IDLE.
//  Clock/reset: one clock domain. Reset is asynchronous assert, synchronous release.
//   All outputs are registered, except wrReady = !full.
//  FIFO: count range 0..DEPTH; pointers ADDR_W bits wide, wrapping naturally DEPTH-1 -> 0.
//  Push: wrValid && !full. Pop: occurs on the LAUNCH->DRAIN transition only.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//  wrValid while full: ignored, with no state change; the producer must hold it.
//  FSM:
//   IDLE:   txStart=0. If !empty && txEn && !txBusy -> LAUNCH next cycle;
//           txByte loads the head byte on this edge.
//   LAUNCH: txStart=1, txByte stable. If txBusy==1 -> pop, txStart=0, go to DRAIN.
//           If txEn==0 -> txStart=0, go to IDLE with no pop; the byte is retained.
//   DRAIN:  txStart=0. If txBusy==0 -> IDLE. Frames are therefore strictly serialised.
//  Latency: a push into an empty idle FIFO raises txStart 2 clk later.
//  txStart is never high while txBusy was high on the previous edge in DRAIN.
//   This means no double-launch of a frame.
//  txEn low in DRAIN: stay in DRAIN until txBusy falls; Uart8 finishes or aborts.
//  Reset mid-frame: FSM returns to IDLE and the queue is lost.
//   Uart8 handles its own frame.
// CONFIGURATION
//  `UART_TX_FEEDER_LEVEL_EN defined:
//   adds output port level [ADDR_W:0], a registered occupancy count (reset 0).
//  Not defined: the port is absent; the count register is kept internally.
//   empty and full are derived from it in both builds.
// STRUCTURE
//  Shared include uart_defs.vh holds:
//   - UART_DATA_W=8
//   - FSM state encodings (IDLE=2'd0, LAUNCH=2'd1, DRAIN=2'd2)
//   - default CLOCK_RATE=12000000 and BAUD_RATE=9600 used by the benches
//  Sub-module uart_sync_fifo (DEPTH, WIDTH params): storage, pointers, count.
//   The FSM and Uart8-side handshake stay in uart_tx_feeder.
// TESTING
//  All scenarios run at 12 MHz / 9600 baud, with feeder -> Uart8 -> Uart8 rx loopback.
//  1. Reset, then one push of 8'h45 with txEn=1
//     -> txStart high 2 clk later; pop when txBusy rises; rx gets 8'h45 with rxErr=0.
//  2. Burst push of 8'h01..8'h04 on consecutive clocks
//     -> rx sees 01,02,03,04 in order; exactly one txStart pulse per frame;
//        empty=1 after the 4th pop.
//  3. Push 17 bytes into DEPTH=16 while txEn=0
//     -> full=1 and wrReady=0 after 16 pushes; the 17th is held off.
//        Raise txEn -> wrReady reasserts after the first pop; all 17 bytes delivered.
//  4. Drop txEn while in LAUNCH, before txBusy rises
//     -> back to IDLE, no pop; on re-enable the same byte is sent.
//  5. Assert reset during the 2nd frame of a 3-byte queue
//     -> empty=1, txStart=0 immediately; no 3rd frame is ever launched.
//  6. With `UART_TX_FEEDER_LEVEL_EN: push 3, pop 1, push and pop on the same edge
//     -> level = 3, 2, 2.

Source files
------------

// File: rtl/uart_tx_feeder_pkg.sv
// Shared constants and FSM state type for the Uart8 transmit feeder.
// CLOCK_RATE/BAUD_RATE are the nominal 12 MHz / 9600 baud operating point.
package uart_tx_feeder_pkg;

  localparam int UART_DATA_W = 8;
  localparam int CLOCK_RATE  = 12_000_000;
  localparam int BAUD_RATE   = 9600;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_DRAIN  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and a registered occupancy count.
// empty/full are registered alongside the count so they settle with it.
module uart_sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int WIDTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [ADDR_W:0]  count,
  output logic             empty,
  output logic             full
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, full_q;
  logic              do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  // NOTE: count_d is assigned a default before the case so no latch is inferred.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; only pointers and count are.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_FULL);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM feeding Uart8 one frame at a time, paced by txBusy.
// Define UART_TX_FEEDER_LEVEL_EN to expose the registered occupancy on port 'level'.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] wrData,
  input  logic                   wrValid,
  output logic                   wrReady,
  input  logic                   txEn,
  input  logic                   txBusy,
  output logic                   txStart,
  output logic [UART_DATA_W-1:0] txByte,
  output logic                   empty,
  output logic                   full
`ifdef UART_TX_FEEDER_LEVEL_EN
  ,
  output logic [ADDR_W:0]        level
`endif
);

  feeder_state_e          state_q;
  logic                   tx_start_q;
  logic [UART_DATA_W-1:0] tx_byte_q;
  logic [UART_DATA_W-1:0] fifo_head;
  logic [ADDR_W:0]        fifo_count;
  logic                   fifo_pop;

  // The byte leaves the queue only once Uart8 has taken it (txBusy seen in LAUNCH).
  assign fifo_pop = (state_q == ST_LAUNCH) && txBusy;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wrValid),
    .pop   (fifo_pop),
    .wdata (wrData),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if ((fifo_count != '0) && txEn && !txBusy) begin
            state_q    <= ST_LAUNCH;
            tx_start_q <= 1'b1;
            tx_byte_q  <= fifo_head;
          end
        end
        ST_LAUNCH: begin
          if (txBusy) begin
            state_q    <= ST_DRAIN;
            tx_start_q <= 1'b0;
          end else if (!txEn) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Wait out the whole frame, even if txEn drops, before relaunching.
          if (!txBusy) state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          tx_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign wrReady = !full;
  assign txStart = tx_start_q;
  assign txByte  = tx_byte_q;

`ifdef UART_TX_FEEDER_LEVEL_EN
  assign level = fifo_count;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: a behavioural Uart8 stand-in plus a queue
// reference model; frame lengths are shortened so the run stays brief.
`timescale 1ns/1ps
module tb_uart_tx_feeder;
  import uart_tx_feeder_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wrData;
  logic       wrValid, wrReady, txEn, txBusy, txStart, empty, full;
  logic [7:0] txByte;
`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [ADDR_W:0] level;
`endif

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wrData  (wrData),
    .wrValid (wrValid),
    .wrReady (wrReady),
    .txEn    (txEn),
    .txBusy  (txBusy),
    .txStart (txStart),
    .txByte  (txByte),
    .empty   (empty),
    .full    (full)
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes the FIFO should hold, in order, and its occupancy.
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  int  cnt = 0, frames = 0, pulses = 0, frame_left = 0, prod_prob = 100;
  bit  push_now = 0, pop_pending = 0, hold_off = 0, push_with_pop = 0, prev_start = 0;

  // One clock: apply the edge to the model, check at the falling edge, then run
  // the Uart8 stand-in and the producer, driving inputs for the next edge.
  task automatic step();
    logic [7:0] head;
    bit offer;
    @(posedge clk);
    if (reset) cnt = 0;
    else cnt = cnt + int'(push_now) - int'(pop_pending);
    push_now    = 0;
    pop_pending = 0;
    @(negedge clk);
    check("empty", empty, cnt == 0);
    check("full", full, cnt == DEPTH);
    check("wrReady", wrReady, cnt != DEPTH);
`ifdef UART_TX_FEEDER_LEVEL_EN
    check("level", level, cnt);
`endif
    if (txBusy) check("no_relaunch", txStart, 0);
    if (txStart && !prev_start) pulses++;
    prev_start = txStart;

    if (txBusy) begin
      frame_left--;
      if (frame_left == 0) txBusy = 1'b0;
    end else if (txStart && txEn && !hold_off) begin
      check("frame_queued", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        head = exp_q.pop_front();
        check("txByte", txByte, head);
      end
      frames++;
      txBusy      = 1'b1;
      frame_left  = $urandom_range(2, 8);
      pop_pending = !reset;
    end

    offer = 0;
    if (!reset && src_q.size() > 0) begin
      if (push_with_pop) offer = pop_pending;
      else offer = wrValid || ($urandom_range(0, 99) < prod_prob);
    end
    wrValid = offer;
    if (offer) begin
      wrData   = src_q[0];
      push_now = (cnt < DEPTH);
      if (push_now) exp_q.push_back(src_q.pop_front());
    end else begin
      wrData = 8'($urandom);
    end
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    wrValid = 1'b0;
    src_q.delete();
    exp_q.delete();
    cnt = 0; push_now = 0; pop_pending = 0;
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_wrReady", wrReady, 1);
    check("rst_txStart", txStart, 0);
    check("rst_txByte", txByte, 8'h00);
`ifdef UART_TX_FEEDER_LEVEL_EN
    check("rst_level", level, 0);
`endif
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int budget = 3000;
    while (frames < n && budget > 0) begin
      step();
      budget--;
    end
    check({tag, "_timeout"}, int'(frames >= n), 1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int f0, p0, budget;
    reset = 1'b0; txEn = 1'b0; txBusy = 1'b0; wrValid = 1'b0; wrData = 8'h00;
    #3;
    apply_reset();

    // Single byte: txStart rises two clocks after wrValid is presented.
    txEn = 1'b1;
    src_q.push_back(8'h45);
    step();
    step();
    check("s1_start_early", txStart, 0);
    step();
    check("s1_start_lat2", txStart, 1);
    check("s1_byte", txByte, 8'h45);
    wait_frames(1, "s1");
    steps(12);
    check("s1_drained", exp_q.size(), 0);

    // Burst of four: in order, one txStart pulse per frame, empty after last pop.
    f0 = frames; p0 = pulses;
    for (int b = 1; b <= 4; b++) src_q.push_back(8'(b));
    wait_frames(f0 + 4, "s2");
    step();
    check("s2_empty", empty, 1);
    steps(12);
    check("s2_pulses", pulses - p0, 4);

    // Seventeen bytes with txEn low: full after sixteen, last one held off.
    txEn = 1'b0;
    f0 = frames;
    for (int b = 0; b < 17; b++) src_q.push_back(8'($urandom));
    steps(22);
    check("s3_full", full, 1);
    check("s3_wrReady", wrReady, 0);
    check("s3_no_start", txStart, 0);
    txEn = 1'b1;
    wait_frames(f0 + 17, "s3");
    steps(12);
    check("s3_empty", empty, 1);

    // txEn dropped in LAUNCH before txBusy: abort without pop, resend later.
    f0 = frames;
    hold_off = 1;
    src_q.push_back(8'hA5);
    budget = 50;
    while (!txStart && budget > 0) begin step(); budget--; end
    check("s4_launch", txStart, 1);
    txEn = 1'b0;
    step();
    check("s4_abort", txStart, 0);
    check("s4_retained", empty, 0);
    steps(4);
    hold_off = 0;
    txEn = 1'b1;
    wait_frames(f0 + 1, "s4");
    steps(12);

    // Reset during the second of three frames: queue lost, no third launch.
    f0 = frames;
    for (int b = 0; b < 3; b++) src_q.push_back(8'(8'h30 + b));
    wait_frames(f0 + 2, "s5");
    step();
    apply_reset();
    steps(60);
    check("s5_no_third", frames - f0, 2);

`ifdef UART_TX_FEEDER_LEVEL_EN
    // Occupancy: push 3, pop 1, then push and pop on the same edge.
    txEn = 1'b0;
    f0 = frames;
    for (int b = 0; b < 3; b++) src_q.push_back(8'(8'h60 + b));
    steps(6);
    check("s6_level3", level, 3);
    txEn = 1'b1;
    wait_frames(f0 + 1, "s6a");
    step();
    check("s6_level2", level, 2);
    src_q.push_back(8'h6F);
    push_with_pop = 1;
    wait_frames(f0 + 2, "s6b");
    step();
    check("s6_level_pushpop", level, 2);
    push_with_pop = 0;
    wait_frames(f0 + 4, "s6c");
    steps(12);
`endif

    // Randomised traffic: bursty producer, txEn flicker, variable Uart8 acceptance.
    prod_prob = 60;
    for (int c = 0; c < 800; c++) begin
      if (src_q.size() < 4 && $urandom_range(0, 3) == 0) src_q.push_back(8'($urandom));
      txEn     = ($urandom_range(0, 15) != 0);
      hold_off = ($urandom_range(0, 7) == 0);
      step();
    end
    txEn = 1'b1;
    hold_off = 0;
    prod_prob = 100;
    wait_frames(frames + exp_q.size() + src_q.size(), "rand");
    steps(12);
    check("rand_drained", exp_q.size(), 0);
    check("rand_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
